id_ex_stage: RTL and testbench

//  ID/EX pipeline register of the 5-stage RV32I core, with load-use hazard detection and WB->ID bypass.

---
 rtl/pipeline_pkg.sv | 41 ++++
 rtl/load_use_detector.sv | 37 +++
 rtl/id_ex_stage.sv | 200 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Types and constants shared by the RV32I pipeline stages: the decoder,
// id_ex_stage, ex_mem_stage and the forwarding logic.
//   ctrl_t      : packed control word that travels with an instruction
//   ALUOP_*     : ALU operation encodings carried in ctrl_t.aluop
//   CTRL_NOP    : all-zero control word; a bubble carries this value
//   CNT_*       : index of each event counter inside id_ex_stage
// ---------------------------------------------------------------------------
package pipeline_pkg;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic [3:0] aluop;
        logic [2:0] funct3;
    } ctrl_t;

    localparam logic [3:0] ALUOP_ADD   = 4'd0;
    localparam logic [3:0] ALUOP_SUB   = 4'd1;
    localparam logic [3:0] ALUOP_AND   = 4'd2;
    localparam logic [3:0] ALUOP_OR    = 4'd3;
    localparam logic [3:0] ALUOP_XOR   = 4'd4;
    localparam logic [3:0] ALUOP_SLL   = 4'd5;
    localparam logic [3:0] ALUOP_SRL   = 4'd6;
    localparam logic [3:0] ALUOP_SRA   = 4'd7;
    localparam logic [3:0] ALUOP_SLT   = 4'd8;
    localparam logic [3:0] ALUOP_SLTU  = 4'd9;
    localparam logic [3:0] ALUOP_PASSB = 4'd10;

    localparam ctrl_t CTRL_NOP = '0;

    localparam int CNT_BUBBLE = 0;
    localparam int CNT_FLUSH  = 1;

endpackage

// File: rtl/load_use_detector.sv
// ---------------------------------------------------------------------------
// load_use_detector
// Purely combinational load-use hazard check. Flags when the instruction in
// ID reads a register that the load currently in EX has not produced yet.
// Kept as its own module so the decoder can reuse the same equation.
// Ports:
//   idex_valid_i, idex_memread_i, idex_rd_i : instruction currently in EX
//   id_valid_i                              : ID holds a real instruction
//   id_rs1_i/id_use_rs1_i, id_rs2_i/id_use_rs2_i : ID source operands
//   hazard_o                                : load-use hazard this cycle
// ---------------------------------------------------------------------------
module load_use_detector #(
    parameter int RAW = 5
) (
    input  logic           idex_valid_i,
    input  logic           idex_memread_i,
    input  logic [RAW-1:0] idex_rd_i,
    input  logic           id_valid_i,
    input  logic [RAW-1:0] id_rs1_i,
    input  logic           id_use_rs1_i,
    input  logic [RAW-1:0] id_rs2_i,
    input  logic           id_use_rs2_i,
    output logic           hazard_o
);

    logic loadInEx;
    logic rs1Match;
    logic rs2Match;

    // A load targeting x0 never produces a value anyone waits for, so it
    // cannot cause a hazard. Operands that are not actually read are ignored.
    assign loadInEx = idex_valid_i && idex_memread_i && (idex_rd_i != '0);
    assign rs1Match = id_use_rs1_i && (id_rs1_i == idex_rd_i);
    assign rs2Match = id_use_rs2_i && (id_rs2_i == idex_rd_i);
    assign hazard_o = loadInEx && id_valid_i && (rs1Match || rs2Match);

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage RV32I core. Captures the decoded
// instruction every cycle, inserts a bubble on a load-use hazard or an EX
// branch flush, bypasses the writeback value into the captured operands,
// and keeps saturating bubble/flush event counters.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   id_*_i                       : decoded ID instruction and regfile data
//   wb_regwrite_i/wb_rd_i/wb_data_i : writeback port (WB->ID bypass source)
//   ex_hold_i                    : downstream stall, keep ID/EX contents
//   ex_flush_i                   : taken branch/jump in EX, kill ID instr
//   stall_fe_o                   : freeze PC and IF/ID (load-use)
//   idex_*_o                     : registered instruction for EX
//   bubble_cnt_o, flush_cnt_o    : saturating event counters
// ---------------------------------------------------------------------------
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [RAW-1:0]   id_rs1_i,
    input  logic [RAW-1:0]   id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [RAW-1:0]   id_rd_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  ctrl_t            id_ctrl_i,
    input  logic             wb_regwrite_i,
    input  logic [RAW-1:0]   wb_rd_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic             ex_hold_i,
    input  logic             ex_flush_i,
    output logic             stall_fe_o,
    output logic             idex_valid_o,
    output logic [XLEN-1:0]  idex_pc_o,
    output logic [RAW-1:0]   idex_rs1_o,
    output logic [RAW-1:0]   idex_rs2_o,
    output logic [RAW-1:0]   idex_rd_o,
    output logic [XLEN-1:0]  idex_rs1_data_o,
    output logic [XLEN-1:0]  idex_rs2_data_o,
    output logic [XLEN-1:0]  idex_imm_o,
    output ctrl_t            idex_ctrl_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic            valid_q,   valid_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [RAW-1:0]  rs1_q,     rs1_d;
    logic [RAW-1:0]  rs2_q,     rs2_d;
    logic [RAW-1:0]  rd_q,      rd_d;
    logic [XLEN-1:0] rs1Data_q, rs1Data_d;
    logic [XLEN-1:0] rs2Data_q, rs2Data_d;
    logic [XLEN-1:0] imm_q,     imm_d;
    ctrl_t           ctrl_q,    ctrl_d;

    logic            hazard;
    logic            bypassRs1;
    logic            bypassRs2;
    logic [1:0]      cntInc;
    logic [1:0][CNT_W-1:0] cntVal;

    load_use_detector #(
        .RAW (RAW)
    ) uHazard (
        .idex_valid_i   (valid_q),
        .idex_memread_i (ctrl_q.memread),
        .idex_rd_i      (rd_q),
        .id_valid_i     (id_valid_i),
        .id_rs1_i       (id_rs1_i),
        .id_use_rs1_i   (id_use_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_use_rs2_i   (id_use_rs2_i),
        .hazard_o       (hazard)
    );

    // The front end only needs to freeze when this stage will actually turn
    // the hazard into a bubble; a flush kills the ID instruction anyway and a
    // hold already freezes everything upstream.
    assign stall_fe_o = hazard && !ex_flush_i && !ex_hold_i && !rst_i;

    // The regfile is written on the same edge this stage captures, so the
    // value being written back is newer than what ID read. x0 is never
    // bypassed because it always reads as zero.
    assign bypassRs1 = wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == id_rs1_i);
    assign bypassRs2 = wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == id_rs2_i);

    // Next-state selection: hold keeps everything, a flush or hazard loads a
    // bubble (flush wins, since the ID instruction is dead either way), and
    // otherwise the ID instruction is captured. A bubble zeroes the register
    // numbers too so the forwarding unit can never match on it.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        rs1Data_d = rs1Data_q;
        rs2Data_d = rs2Data_q;
        imm_d     = imm_q;
        ctrl_d    = ctrl_q;
        cntInc    = 2'b00;

        if (!ex_hold_i) begin
            if (ex_flush_i || hazard) begin
                valid_d   = 1'b0;
                pc_d      = '0;
                rs1_d     = '0;
                rs2_d     = '0;
                rd_d      = '0;
                rs1Data_d = '0;
                rs2Data_d = '0;
                imm_d     = '0;
                ctrl_d    = CTRL_NOP;
                cntInc[CNT_FLUSH]  = ex_flush_i;
                cntInc[CNT_BUBBLE] = !ex_flush_i;
            end else begin
                valid_d   = id_valid_i;
                pc_d      = id_pc_i;
                rs1_d     = id_rs1_i;
                rs2_d     = id_rs2_i;
                rd_d      = id_rd_i;
                rs1Data_d = bypassRs1 ? wb_data_i : id_rs1_data_i;
                rs2Data_d = bypassRs2 ? wb_data_i : id_rs2_data_i;
                imm_d     = id_imm_i;
                ctrl_d    = id_ctrl_i;
            end
        end
    end

    // Pipeline register with synchronous reset to an empty NOP slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rs1Data_q <= '0;
            rs2Data_q <= '0;
            imm_q     <= '0;
            ctrl_q    <= CTRL_NOP;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            rs1Data_q <= rs1Data_d;
            rs2Data_q <= rs2Data_d;
            imm_q     <= imm_d;
            ctrl_q    <= ctrl_d;
        end
    end

    // One saturating counter per event type. Sticking at all-ones keeps a
    // long-running count from wrapping back to a misleadingly small value.
    for (genvar g = 0; g < 2; g++) begin : gEvtCnt
        logic [CNT_W-1:0] count_q, count_d;

        always_comb begin
            count_d = count_q;
            if (cntInc[g] && (count_q != {CNT_W{1'b1}})) begin
                count_d = count_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end

        assign cntVal[g] = count_q;
    end

    assign idex_valid_o    = valid_q;
    assign idex_pc_o       = pc_q;
    assign idex_rs1_o      = rs1_q;
    assign idex_rs2_o      = rs2_q;
    assign idex_rd_o       = rd_q;
    assign idex_rs1_data_o = rs1Data_q;
    assign idex_rs2_data_o = rs2Data_q;
    assign idex_imm_o      = imm_q;
    assign idex_ctrl_o     = ctrl_q;
    assign bubble_cnt_o    = cntVal[CNT_BUBBLE];
    assign flush_cnt_o     = cntVal[CNT_FLUSH];

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage. Two copies of the stage share the same
// inputs: one with 16-bit counters and one with 4-bit counters so that
// counter saturation can be reached in a few dozen cycles.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
    import pipeline_pkg::*;

    localparam ctrl_t LW_CTRL  = '{regwrite: 1'b1, memread: 1'b1, memwrite: 1'b0,
                                   memtoreg: 1'b1, alusrc: 1'b1, branch: 1'b0,
                                   jump: 1'b0, aluop: ALUOP_ADD, funct3: 3'b010};
    localparam ctrl_t ADD_CTRL = '{regwrite: 1'b1, memread: 1'b0, memwrite: 1'b0,
                                   memtoreg: 1'b0, alusrc: 1'b0, branch: 1'b0,
                                   jump: 1'b0, aluop: ALUOP_ADD, funct3: 3'b000};
    localparam ctrl_t SW_CTRL  = '{regwrite: 1'b0, memread: 1'b0, memwrite: 1'b1,
                                   memtoreg: 1'b0, alusrc: 1'b1, branch: 1'b0,
                                   jump: 1'b0, aluop: ALUOP_ADD, funct3: 3'b010};

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    ctrl_t       id_ctrl;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_hold, ex_flush;

    logic        stall_fe, idex_valid;
    logic [31:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
    logic [4:0]  idex_rs1, idex_rs2, idex_rd;
    ctrl_t       idex_ctrl;
    logic [15:0] bubble_cnt, flush_cnt;

    logic        stall_fe4, idex_valid4;
    logic [31:0] idex_pc4, idex_rs1_data4, idex_rs2_data4, idex_imm4;
    logic [4:0]  idex_rs14, idex_rs24, idex_rd4;
    ctrl_t       idex_ctrl4;
    logic [3:0]  bubble_cnt4, flush_cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_pc_i(id_pc),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1),
        .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd), .id_rs1_data_i(id_rs1_data),
        .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm), .id_ctrl_i(id_ctrl),
        .wb_regwrite_i(wb_regwrite), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .ex_hold_i(ex_hold), .ex_flush_i(ex_flush), .stall_fe_o(stall_fe),
        .idex_valid_o(idex_valid), .idex_pc_o(idex_pc), .idex_rs1_o(idex_rs1),
        .idex_rs2_o(idex_rs2), .idex_rd_o(idex_rd), .idex_rs1_data_o(idex_rs1_data),
        .idex_rs2_data_o(idex_rs2_data), .idex_imm_o(idex_imm), .idex_ctrl_o(idex_ctrl),
        .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt)
    );

    id_ex_stage #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_pc_i(id_pc),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1),
        .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd), .id_rs1_data_i(id_rs1_data),
        .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm), .id_ctrl_i(id_ctrl),
        .wb_regwrite_i(wb_regwrite), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .ex_hold_i(ex_hold), .ex_flush_i(ex_flush), .stall_fe_o(stall_fe4),
        .idex_valid_o(idex_valid4), .idex_pc_o(idex_pc4), .idex_rs1_o(idex_rs14),
        .idex_rs2_o(idex_rs24), .idex_rd_o(idex_rd4), .idex_rs1_data_o(idex_rs1_data4),
        .idex_rs2_data_o(idex_rs2_data4), .idex_imm_o(idex_imm4), .idex_ctrl_o(idex_ctrl4),
        .bubble_cnt_o(bubble_cnt4), .flush_cnt_o(flush_cnt4)
    );

    // Present one decoded instruction on the ID inputs.
    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic [4:0] rd, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] imm,
                                 input ctrl_t c);
        id_valid    = v;
        id_pc       = pc;
        id_rs1      = rs1;
        id_use_rs1  = u1;
        id_rs2      = rs2;
        id_use_rs2  = u2;
        id_rd       = rd;
        id_rs1_data = d1;
        id_rs2_data = d2;
        id_imm      = imm;
        id_ctrl     = c;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;

        // Reset with random inputs for two cycles.
        rst = 1'b1;
        ex_hold = 1'b0; ex_flush = 1'b0;
        wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
        for (int i = 0; i < 2; i++) begin
            r = $urandom;
            applyStimulus(r[0], $urandom, r[8:4], r[1], r[13:9], r[2], r[18:14],
                          $urandom, $urandom, $urandom, r[31:18]);
            ex_hold = r[3];
            ex_flush = r[19];
            wb_regwrite = r[20];
            wb_rd = r[25:21];
            wb_data = $urandom;
            #1;
            checkOutput("rst_stall", {31'd0, stall_fe}, 32'd0);
            tick();
        end
        checkOutput("rst_valid",  {31'd0, idex_valid}, 32'd0);
        checkOutput("rst_pc",     idex_pc, 32'd0);
        checkOutput("rst_rs1",    {27'd0, idex_rs1}, 32'd0);
        checkOutput("rst_rd",     {27'd0, idex_rd}, 32'd0);
        checkOutput("rst_rs1dat", idex_rs1_data, 32'd0);
        checkOutput("rst_imm",    idex_imm, 32'd0);
        checkOutput("rst_ctrl",   {18'd0, idex_ctrl}, 32'd0);
        checkOutput("rst_bubble", {16'd0, bubble_cnt}, 32'd0);
        checkOutput("rst_flush",  {16'd0, flush_cnt}, 32'd0);
        checkOutput("rst_stall2", {31'd0, stall_fe}, 32'd0);

        rst = 1'b0;
        ex_hold = 1'b0; ex_flush = 1'b0;
        wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTRL_NOP);
        tick();

        // Load-use: lw x5 then add x6,x5,x7.
        applyStimulus(1'b1, 32'h100, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 32'h1000, 0, 32'd4, LW_CTRL);
        #1;
        checkOutput("lu_nostall_empty", {31'd0, stall_fe}, 32'd0);
        tick();
        checkOutput("lu_lw_valid", {31'd0, idex_valid}, 32'd1);
        checkOutput("lu_lw_rd",    {27'd0, idex_rd}, 32'd5);
        checkOutput("lu_lw_ctrl",  {18'd0, idex_ctrl}, {18'd0, LW_CTRL});
        checkOutput("lu_lw_pc",    idex_pc, 32'h100);
        checkOutput("lu_lw_rs1d",  idex_rs1_data, 32'h1000);
        checkOutput("lu_lw_imm",   idex_imm, 32'd4);
        applyStimulus(1'b1, 32'h104, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 32'h11, 32'h22, 0, ADD_CTRL);
        #1;
        checkOutput("lu_stall", {31'd0, stall_fe}, 32'd1);
        tick();
        checkOutput("lu_bub_valid", {31'd0, idex_valid}, 32'd0);
        checkOutput("lu_bub_ctrl",  {18'd0, idex_ctrl}, 32'd0);
        checkOutput("lu_bub_rd",    {27'd0, idex_rd}, 32'd0);
        checkOutput("lu_bub_rs1",   {27'd0, idex_rs1}, 32'd0);
        checkOutput("lu_bub_pc",    idex_pc, 32'd0);
        checkOutput("lu_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
        checkOutput("lu_stall_after", {31'd0, stall_fe}, 32'd0);
        tick();
        checkOutput("lu_add_valid", {31'd0, idex_valid}, 32'd1);
        checkOutput("lu_add_pc",    idex_pc, 32'h104);
        checkOutput("lu_add_rs1",   {27'd0, idex_rs1}, 32'd5);
        checkOutput("lu_add_rs2",   {27'd0, idex_rs2}, 32'd7);
        checkOutput("lu_add_rd",    {27'd0, idex_rd}, 32'd6);
        checkOutput("lu_add_rs2d",  idex_rs2_data, 32'h22);
        checkOutput("lu_add_ctrl",  {18'd0, idex_ctrl}, {18'd0, ADD_CTRL});
        checkOutput("lu_add_bcnt",  {16'd0, bubble_cnt}, 32'd1);

        // No false hazard: load to x0.
        applyStimulus(1'b1, 32'h108, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 0, 0, 0, LW_CTRL);
        tick();
        applyStimulus(1'b1, 32'h10C, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 0, 0, 0, ADD_CTRL);
        #1;
        checkOutput("nf_x0", {31'd0, stall_fe}, 32'd0);
        // No false hazard: load slot not valid.
        applyStimulus(1'b0, 32'h110, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 0, 0, 0, LW_CTRL);
        tick();
        checkOutput("nf_inv_valid", {31'd0, idex_valid}, 32'd0);
        checkOutput("nf_inv_rd", {27'd0, idex_rd}, 32'd5);
        applyStimulus(1'b1, 32'h114, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 0, 0, 0, ADD_CTRL);
        #1;
        checkOutput("nf_invalid_load", {31'd0, stall_fe}, 32'd0);
        // No false hazard: sw whose rs2 matches but is flagged unused.
        applyStimulus(1'b1, 32'h118, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 0, 0, 0, LW_CTRL);
        tick();
        applyStimulus(1'b1, 32'h11C, 5'd1, 1'b1, 5'd5, 1'b0, 5'd0, 0, 0, 0, SW_CTRL);
        #1;
        checkOutput("nf_sw_unused", {31'd0, stall_fe}, 32'd0);
        id_use_rs2 = 1'b1;
        #1;
        checkOutput("sw_rs2_used", {31'd0, stall_fe}, 32'd1);
        tick();
        checkOutput("sw_bubble_cnt", {16'd0, bubble_cnt}, 32'd2);

        // Flush beats hazard.
        applyStimulus(1'b1, 32'h120, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 0, 0, 0, LW_CTRL);
        tick();
        applyStimulus(1'b1, 32'h124, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 0, 0, 0, ADD_CTRL);
        ex_flush = 1'b1;
        #1;
        checkOutput("fl_stall", {31'd0, stall_fe}, 32'd0);
        tick();
        ex_flush = 1'b0;
        checkOutput("fl_valid",  {31'd0, idex_valid}, 32'd0);
        checkOutput("fl_ctrl",   {18'd0, idex_ctrl}, 32'd0);
        checkOutput("fl_fcnt",   {16'd0, flush_cnt}, 32'd1);
        checkOutput("fl_bcnt",   {16'd0, bubble_cnt}, 32'd2);

        // Hold for 3 cycles with a hazard and changing ID inputs.
        applyStimulus(1'b1, 32'h200, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 32'h77, 0, 32'd8, LW_CTRL);
        tick();
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(i * 4), 5'd5, 1'b1, 5'(i), 1'b1, 5'd9,
                          32'(i), 32'(i), 32'(i), ADD_CTRL);
            ex_flush = (i == 1);
            #1;
            checkOutput("hold_stall", {31'd0, stall_fe}, 32'd0);
            tick();
            checkOutput("hold_pc",    idex_pc, 32'h200);
            checkOutput("hold_valid", {31'd0, idex_valid}, 32'd1);
            checkOutput("hold_rd",    {27'd0, idex_rd}, 32'd5);
            checkOutput("hold_rs1d",  idex_rs1_data, 32'h77);
            checkOutput("hold_bcnt",  {16'd0, bubble_cnt}, 32'd2);
            checkOutput("hold_fcnt",  {16'd0, flush_cnt}, 32'd1);
        end
        ex_hold = 1'b0;
        ex_flush = 1'b0;
        #1;
        checkOutput("unhold_stall", {31'd0, stall_fe}, 32'd1);
        tick();
        checkOutput("unhold_bcnt", {16'd0, bubble_cnt}, 32'd3);

        // WB->ID bypass.
        applyStimulus(1'b1, 32'h400, 5'd3, 1'b1, 5'd4, 1'b1, 5'd7, 32'd0, 32'h55, 0, ADD_CTRL);
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        tick();
        checkOutput("byp_rs1", idex_rs1_data, 32'hDEADBEEF);
        checkOutput("byp_rs1_other", idex_rs2_data, 32'h55);
        applyStimulus(1'b1, 32'h404, 5'd3, 1'b1, 5'd4, 1'b1, 5'd7, 32'h33, 32'h44, 0, ADD_CTRL);
        wb_rd = 5'd4; wb_data = 32'hCAFEF00D;
        tick();
        checkOutput("byp_rs2", idex_rs2_data, 32'hCAFEF00D);
        checkOutput("byp_rs2_other", idex_rs1_data, 32'h33);
        applyStimulus(1'b1, 32'h408, 5'd0, 1'b1, 5'd4, 1'b1, 5'd7, 32'd0, 32'h44, 0, ADD_CTRL);
        wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
        tick();
        checkOutput("byp_x0", idex_rs1_data, 32'd0);
        applyStimulus(1'b1, 32'h40C, 5'd3, 1'b1, 5'd4, 1'b1, 5'd7, 32'h12, 32'h44, 0, ADD_CTRL);
        wb_regwrite = 1'b0; wb_rd = 5'd3;
        tick();
        checkOutput("byp_nowrite", idex_rs1_data, 32'h12);
        wb_rd = 5'd0; wb_data = 32'd0;

        // Saturation: a self-dependent load produces one hazard every 2 edges.
        applyStimulus(1'b1, 32'h500, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 0, 0, 0, LW_CTRL);
        for (int i = 0; i < 12; i++) begin
            tick();
            tick();
        end
        checkOutput("sat4_reach", {28'd0, bubble_cnt4}, 32'd15);
        checkOutput("sat16_mid",  {16'd0, bubble_cnt}, 32'd15);
        for (int i = 0; i < 6; i++) begin
            tick();
            tick();
        end
        checkOutput("sat4_hold",   {28'd0, bubble_cnt4}, 32'd15);
        checkOutput("sat16_count", {16'd0, bubble_cnt}, 32'd21);
        checkOutput("sat4_fcnt",   {28'd0, flush_cnt4}, 32'd1);

        // Reset in the middle of a stall.
        tick();
        #1;
        checkOutput("mid_stall", {31'd0, stall_fe}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_stall", {31'd0, stall_fe}, 32'd0);
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_valid", {31'd0, idex_valid}, 32'd0);
        checkOutput("mid_rst_rd",    {27'd0, idex_rd}, 32'd0);
        checkOutput("mid_rst_ctrl",  {18'd0, idex_ctrl}, 32'd0);
        checkOutput("mid_rst_bcnt",  {16'd0, bubble_cnt}, 32'd0);
        checkOutput("mid_rst_fcnt",  {16'd0, flush_cnt}, 32'd0);
        checkOutput("mid_rst_bcnt4", {28'd0, bubble_cnt4}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
